// File: rtl/ucode_sequencer_if.sv
// Decoder-side bundle for the micro-step sequencer: decoder/bus inputs and sequencing outputs.
// The master drives decoder status and bus data; the slave is the sequencer itself.
interface ucode_sequencer_if #(
    parameter int unsigned STEP_W = 3,
    parameter int unsigned N_IRQ  = 5
);
    logic              stall;
    logic [7:0]        db_in;
    logic              dec_done;
    logic              dec_is_cond;
    logic [STEP_W-1:0] dec_next_cond;
    logic [3:0]        flags;
    logic              ime_set;
    logic              ime_set_now;
    logic              ime_clr;
    logic              halt_req;
    logic [N_IRQ-1:0]  irq_pending;
    logic [7:0]        ir;
    logic              cb_mode;
    logic [STEP_W-1:0] step;
    logic              dispatch;
    logic [7:0]        irq_vec;
    logic [N_IRQ-1:0]  irq_ack;
    logic              ime;
    logic              halted;
    logic              seq_err;

    modport master (
        output stall, db_in, dec_done, dec_is_cond, dec_next_cond, flags,
               ime_set, ime_set_now, ime_clr, halt_req, irq_pending,
        input  ir, cb_mode, step, dispatch, irq_vec, irq_ack, ime, halted, seq_err
    );

    modport slave (
        input  stall, db_in, dec_done, dec_is_cond, dec_next_cond, flags,
               ime_set, ime_set_now, ime_clr, halt_req, irq_pending,
        output ir, cb_mode, step, dispatch, irq_vec, irq_ack, ime, halted, seq_err
    );
endinterface

// File: rtl/ucode_sequencer.sv
// SM83 sequencing front end: instruction register, M-cycle step counter, CB prefix,
// conditional branch resolution, IME/EI delay, HALT and interrupt dispatch.
module ucode_sequencer #(
    parameter int unsigned STEP_W     = 3,
    parameter int unsigned N_IRQ      = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int unsigned VEC_STRIDE = 8
) (
    input logic             clk,
    input logic             rst,
    ucode_sequencer_if.slave bus
);
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DISPATCH} state_e;

    localparam logic [STEP_W-1:0] STEP_MAX  = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(4);
    localparam logic [N_IRQ-1:0]  ACK_ONE   = N_IRQ'(1);

    state_e            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              cb_mode_q, cb_mode_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        irq_vec_q, irq_vec_d;
    logic              ime_q, ime_d;
    logic              ei_pending_q, ei_pending_d;
    logic              seq_err_q, seq_err_d;

    logic [2:0]        pend_sel;
    logic              pend_any;
    logic              cc_true;
    logic              cb_prefix;
    logic              enter_irq;
    logic [N_IRQ-1:0]  irq_ack;

    always_comb begin
        pend_sel = '0;
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (bus.irq_pending[i-1]) pend_sel = 3'(i - 1);
        end
    end

    assign pend_any  = |bus.irq_pending;
    assign cb_prefix = (ir_q == 8'hCB) && !cb_mode_q;

    always_comb begin
        unique case (ir_q[4:3])
            2'd0:    cc_true = !bus.flags[3];
            2'd1:    cc_true =  bus.flags[3];
            2'd2:    cc_true = !bus.flags[0];
            default: cc_true =  bus.flags[0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            ir_q         <= '0;
            step_q       <= '0;
            cb_mode_q    <= 1'b0;
            sel_q        <= '0;
            irq_vec_q    <= VEC_BASE;
            ime_q        <= 1'b0;
            ei_pending_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            step_q       <= step_d;
            cb_mode_q    <= cb_mode_d;
            sel_q        <= sel_d;
            irq_vec_q    <= irq_vec_d;
            ime_q        <= ime_d;
            ei_pending_q <= ei_pending_d;
            seq_err_q    <= seq_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        step_d       = step_q;
        cb_mode_d    = cb_mode_q;
        sel_d        = sel_q;
        irq_vec_d    = irq_vec_q;
        ime_d        = ime_q;
        ei_pending_d = ei_pending_q;
        seq_err_d    = seq_err_q;
        enter_irq    = 1'b0;
        if (!bus.stall) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.dec_done) begin
                        step_d = '0;
                        // EI takes effect after this boundary's interrupt check, which uses ime_q
                        if (ei_pending_q) begin
                            ime_d        = 1'b1;
                            ei_pending_d = 1'b0;
                        end
                        if (bus.halt_req) begin
                            state_d = ST_HALT;
                        end else if (ime_q && pend_any && !cb_prefix) begin
                            enter_irq = 1'b1;
                        end else begin
                            ir_d      = bus.db_in;
                            cb_mode_d = cb_prefix;
                        end
                    end else if (bus.dec_is_cond && !cc_true) begin
                        step_d = bus.dec_next_cond;
                    end else if (step_q == STEP_MAX) begin
                        seq_err_d = 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                ST_HALT: begin
                    if (pend_any) begin
                        if (ime_q) begin
                            enter_irq = 1'b1;
                        end else begin
                            state_d   = ST_RUN;
                            step_d    = '0;
                            ir_d      = 8'h00;
                            cb_mode_d = 1'b0;
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (step_q == STEP_LAST) begin
                        state_d   = ST_RUN;
                        step_d    = '0;
                        ir_d      = 8'h00;
                        cb_mode_d = 1'b0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase

            if (enter_irq) begin
                state_d   = ST_DISPATCH;
                step_d    = '0;
                ime_d     = 1'b0;
                sel_d     = pend_sel;
                irq_vec_d = VEC_BASE + 8'(pend_sel) * 8'(VEC_STRIDE);
            end

            if (bus.ime_clr) begin
                ime_d        = 1'b0;
                ei_pending_d = 1'b0;
            end else if (bus.ime_set_now) begin
                ime_d = 1'b1;
            end else if (bus.ime_set) begin
                ei_pending_d = 1'b1;
            end
        end
    end

    always_comb begin
        irq_ack = '0;
        if (state_q == ST_DISPATCH && step_q == STEP_LAST && !bus.stall) irq_ack = ACK_ONE << sel_q;
    end

    assign bus.ir       = ir_q;
    assign bus.cb_mode  = cb_mode_q;
    assign bus.step     = step_q;
    assign bus.dispatch = (state_q == ST_DISPATCH);
    assign bus.irq_vec  = irq_vec_q;
    assign bus.irq_ack  = irq_ack;
    assign bus.ime      = ime_q;
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.seq_err  = seq_err_q;
endmodule
